hue_wheel_sequencer: RTL
========================

Name: hue_wheel_sequencer

Overview:
Parametrised successor to the fixed six-colour cycler on the iCEBlinkPico RGB LED: walks the same hue wheel (red, yellow, green, cyan, blue, magenta) with per-channel PWM brightness. Adds a linear crossfade mode, reverse direction, pause with single-step, and a sector-wrap strobe. Drives the board RGB LED pins directly from the 12 MHz clock domain.

Parameters:
TICK_CYCLES, 7812, clk cycles per position tick; must be ≥1; 7812 gives about 1 s per full wheel at 12 MHz with PWM_BITS=8.
PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS-1; PWM period = 2^PWM_BITS cycles.

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  synchronous reset, active-high
enable  in  1  1 = run on prescaler ticks; 0 = paused
dir  in  1  0 = forward (R→Y→G→C→B→M), 1 = reverse
fade_mode  in  1  1 = linear crossfade within sector; 0 = hard step colours
step_req  in  1  while paused, each cycle high = one position step
red  out  1  PWM output, active-high
green  out  1  PWM output, active-high
blue  out  1  PWM output, active-high
sector  out  3  current sector 0..5, binary
sector_wrap  out  1  one-cycle strobe on wheel wrap

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset state: prescaler=0, pos=0, sector=0, pwm_cnt=0, latched levels R/G/B=0. Outputs red/green/blue/sector_wrap=0, sector=0.
- Prescaler runs 0..TICK_CYCLES-1 while enable=1. It is held at 0 while enable=0. tick = enable && prescaler==TICK_CYCLES-1.
- Step event = tick, or (enable=0 && step_req=1). step_req is ignored when enable=1.
- Forward step: if pos==MAX, then pos←0 and sector←(sector==5 ? 0 : sector+1); otherwise pos←pos+1.
- Reverse step: if pos==0, then pos←MAX and sector←(sector==0 ? 5 : sector-1); otherwise pos←pos-1.
- dir is sampled at each step event. A change in dir takes effect on the next step and leaves pos and sector unchanged.
- Sector period = TICK_CYCLES·2^PWM_BITS cycles in both modes.
- Level function, with p = pos in fade mode and p = 0 in step mode (R, G, B):
  - sector 0: MAX, p, 0
  - sector 1: MAX-p, MAX, 0
  - sector 2: 0, MAX, p
  - sector 3: 0, MAX-p, MAX
  - sector 4: p, 0, MAX
  - sector 5: MAX, 0, MAX-p
  - In step mode, sectors 0..5 therefore show red, yellow, green, cyan, blue, magenta.
- PWM: pwm_cnt is free-running, PWM_BITS wide, and wraps MAX→0.
- Level latching: levels are latched from the level function in the cycle where pwm_cnt==MAX, and take effect from the next pwm_cnt=0. There is no mid-period glitch.
- Output registers: red ← (pwm_cnt < latched R), and likewise for green and blue. Duty = level/2^PWM_BITS, so MAX gives (2^PWM_BITS-1)/2^PWM_BITS and 0 gives always off.
- After reset, the first PWM period (2^PWM_BITS cycles) outputs all-off. Sector-0 levels apply from the following period.
- sector is a registered copy of the sector state.
- sector_wrap is high for exactly one cycle, the cycle after a 5→0 (forward) or 0→5 (reverse) transition, whether the transition came from a tick or a step_req.
- rst mid-operation overrides everything in that cycle, including a simultaneous tick or step_req. All state returns to reset values on the next edge.
- Changing fade_mode or enable never disturbs pos, sector or pwm_cnt.
- fade_mode affects only the levels latched at the next pwm_cnt==MAX.

Test Plan:
Use TICK_CYCLES=4, PWM_BITS=3, MAX=7 for all scenarios.
1. Hard step: rst, then enable=1, fade_mode=0, dir=0.
   -> sector=0 for 32 cycles, then 1.
   -> After the first PWM period, red is high 7 of every 8 cycles and green/blue are 0.
   -> In sector 1, red and green are both 7/8.
2. Fade: fade_mode=1, dir=0; run to sector 0 with pos=3.
   -> For the next latched period, green is high exactly 3 of 8 cycles and red 7 of 8.
   -> In sector 1 at pos=5, red is 2/8.
3. Wrap: forward from reset for 192 cycles.
   -> sector goes 5→0; sector_wrap is a single 1-cycle pulse; no other pulses in 192 cycles.
4. Reverse: rst, dir=1, enable=1.
   -> First tick (cycle 4) sets pos=7, sector=5; sector_wrap pulses once.
   -> In fade mode, blue level is then 0.
5. Pause/step: enable=0, step_req high for 3 cycles.
   -> pos advances by exactly 3 and the prescaler stays 0.
   -> step_req high with enable=1 causes no extra steps.
6. Reset mid-run: assert rst in sector 3 with a tick coincident.
   -> Next cycle: sector=0, all outputs 0, sector_wrap=0.
   -> Normal sequence restarts identically to scenario 1.

Source files
------------

// File: rtl/hue_wheel_sequencer_if.sv
// -----------------------------------------------------------------------------
// hue_wheel_sequencer_if
//
// Control and LED bundle for hue_wheel_sequencer.
//   enable      : 1 = advance on prescaler ticks, 0 = paused
//   dir         : 0 = forward (R->Y->G->C->B->M), 1 = reverse
//   fade_mode   : 1 = linear crossfade within a sector, 0 = hard colour steps
//   step_req    : while paused, every cycle high advances one position
//   red/green/blue : active-high PWM LED drives
//   sector      : current wheel sector 0..5
//   sector_wrap : one-cycle strobe when the wheel wraps between sector 5 and 0
//
// master drives the controls (system / testbench), slave is the sequencer.
// -----------------------------------------------------------------------------
interface hue_wheel_sequencer_if;
    logic       enable;
    logic       dir;
    logic       fade_mode;
    logic       step_req;
    logic       red;
    logic       green;
    logic       blue;
    logic [2:0] sector;
    logic       sector_wrap;

    modport master (
        output enable, dir, fade_mode, step_req,
        input  red, green, blue, sector, sector_wrap
    );

    modport slave (
        input  enable, dir, fade_mode, step_req,
        output red, green, blue, sector, sector_wrap
    );
endinterface

// File: rtl/hue_wheel_sequencer.sv
// -----------------------------------------------------------------------------
// hue_wheel_sequencer
//
// Walks the RGB hue wheel (red, yellow, green, cyan, blue, magenta) and drives
// three PWM LED outputs. Each sector is split into 2^PWM_BITS positions; a
// position advances on every prescaler tick (TICK_CYCLES clocks) or, while
// paused, on every cycle step_req is high. In fade mode the position blends
// linearly towards the next colour; in step mode each sector is a flat colour.
//
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : hue_wheel_sequencer_if.slave (controls in, LED drives/status out)
//
// Parameters:
//   TICK_CYCLES : clocks per position tick (>= 1)
//   PWM_BITS    : brightness resolution; PWM period is 2^PWM_BITS clocks
// -----------------------------------------------------------------------------
module hue_wheel_sequencer #(
    parameter int TICK_CYCLES = 7812,
    parameter int PWM_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    hue_wheel_sequencer_if.slave  bus
);

    localparam int                  PS_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(TICK_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] MAX     = '1;

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pos;
    logic [2:0]          sector_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] lvl_r, lvl_g, lvl_b;
    logic                red_q, green_q, blue_q, wrap_q;

    logic                tick;
    logic                step;
    logic [PWM_BITS-1:0] pos_next;
    logic [2:0]          sector_next;
    logic                wrap_next;
    logic [PWM_BITS-1:0] p;
    logic [PWM_BITS-1:0] want_r, want_g, want_b;

    // step_req only counts while paused, so a running wheel never double-steps.
    assign tick = bus.enable && (prescaler == PS_LAST);
    assign step = tick || (!bus.enable && bus.step_req);

    // Position/sector successor. dir is looked at only when a step happens,
    // so flipping it between steps leaves pos and sector where they are.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        pos_next    = pos;
        sector_next = sector_q;
        wrap_next   = 1'b0;
        if (step) begin
            if (!bus.dir) begin
                if (pos == MAX) begin
                    pos_next = '0;
                    if (sector_q == 3'd5) begin
                        sector_next = 3'd0;
                        wrap_next   = 1'b1;
                    end else begin
                        sector_next = sector_q + 3'd1;
                    end
                end else begin
                    pos_next = pos + 1'b1;
                end
            end else begin
                if (pos == '0) begin
                    pos_next = MAX;
                    if (sector_q == 3'd0) begin
                        sector_next = 3'd5;
                        wrap_next   = 1'b1;
                    end else begin
                        sector_next = sector_q - 3'd1;
                    end
                end else begin
                    pos_next = pos - 1'b1;
                end
            end
        end
    end

    // Level function: each sector ramps exactly one channel up or down, so the
    // colour is continuous across sector boundaries in fade mode.
    always_comb begin
        p      = bus.fade_mode ? pos : '0;
        want_r = '0;
        want_g = '0;
        want_b = '0;
        case (sector_q)
            3'd0: begin want_r = MAX;     want_g = p;       want_b = '0;      end
            3'd1: begin want_r = MAX - p; want_g = MAX;     want_b = '0;      end
            3'd2: begin want_r = '0;      want_g = MAX;     want_b = p;       end
            3'd3: begin want_r = '0;      want_g = MAX - p; want_b = MAX;     end
            3'd4: begin want_r = p;       want_g = '0;      want_b = MAX;     end
            3'd5: begin want_r = MAX;     want_g = '0;      want_b = MAX - p; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            prescaler <= '0;
            pos       <= '0;
            sector_q  <= 3'd0;
            pwm_cnt   <= '0;
            lvl_r     <= '0;
            lvl_g     <= '0;
            lvl_b     <= '0;
            red_q     <= 1'b0;
            green_q   <= 1'b0;
            blue_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            if (!bus.enable || tick) prescaler <= '0;
            else                     prescaler <= prescaler + 1'b1;

            pos      <= pos_next;
            sector_q <= sector_next;
            wrap_q   <= wrap_next;

            pwm_cnt <= pwm_cnt + 1'b1;
            // Levels only change at the period boundary, so a duty cycle is
            // never cut short or stretched mid-period.
            if (pwm_cnt == MAX) begin
                lvl_r <= want_r;
                lvl_g <= want_g;
                lvl_b <= want_b;
            end

            red_q   <= (pwm_cnt < lvl_r);
            green_q <= (pwm_cnt < lvl_g);
            blue_q  <= (pwm_cnt < lvl_b);
        end
    end

    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.sector      = sector_q;
    assign bus.sector_wrap = wrap_q;

endmodule
